// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction-fetch stage of the Simple_CPU, directly upstream of the control
//   decoder. It holds the PC, fetches one word per instruction from
//   instruction memory over a req/ack handshake, presents the fetched word
//   and its op field to control, and advances the PC using control's
//   branch/jump decisions and the ALU zero flag.
//
//   Optional feature: define INSTR_COUNT_EN to build a 32-bit retired-
//   instruction counter. Without it retired_cnt is tied to zero and no
//   counter flops exist.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous, active-high reset
//   imem_req     out  1   fetch request to instruction memory
//   imem_addr    out  32  fetch address (always equals pc)
//   imem_ack     in   1   imem_rdata is valid this cycle
//   imem_rdata   in   32  fetched instruction word
//   instr        out  32  registered current instruction
//   op           out  6   instr[31:26], to control
//   instr_valid  out  1   instr is valid for the datapath
//   instr_ready  in   1   datapath has executed instr; advance PC
//   branch       in   1   BEQ decode from control
//   zero         in   1   ALU zero flag
//   jump         in   1   J decode from control
//   pc           out  32  current PC
//   retired_cnt  out  32  retired-instruction count (0 unless INSTR_COUNT_EN)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] retired_cnt
);

  typedef enum logic [0:0] {
    REQ  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        load_instr;
  logic        advance;
  logic [31:0] next_pc;

  // Next-PC selection. All arithmetic is modulo 2^32; the branch offset is a
  // signed word displacement relative to pc+4, so an offset of -1 yields a
  // self-loop. Jump wins over a taken branch.
  function automatic logic [31:0] calc_next_pc(
    input logic [31:0] cur_pc,
    input logic [31:0] cur_instr,
    input logic        br,
    input logic        zf,
    input logic        jmp
  );
    logic        [31:0] pc4;
    logic signed [31:0] br_off;
    logic        [31:0] result;
    pc4    = cur_pc + 32'd4;
    br_off = {{14{cur_instr[15]}}, cur_instr[15:0], 2'b00};
    if (jmp) begin
      result = {pc4[31:28], cur_instr[25:0], 2'b00};
    end else if (br && zf) begin
      result = pc4 + $unsigned(br_off);
    end else begin
      result = pc4;
    end
    return result;
  endfunction

  assign next_pc = calc_next_pc(pc, instr, branch, zero, jump);

  // Next-state decode. branch/zero/jump/instr_ready only matter in HOLD;
  // imem_ack only matters in REQ, so a stray ack during HOLD is ignored.
  always_comb begin
    state_nxt  = state;
    load_instr = 1'b0;
    advance    = 1'b0;
    case (state)
      REQ: begin
        if (imem_ack) begin
          load_instr = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          advance   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  // The request is masked by rst so memory never sees a fetch while the
  // unit is being reset, including the cycles before the first reset edge.
  assign imem_req    = (state == REQ) && !rst;
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign op          = instr[31:26];

  // Fetch stage register: state, PC and the latched instruction word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (load_instr) begin
        instr <= imem_rdata;
      end
      if (advance) begin
        pc <= next_pc;
      end
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] retired_q;

  // One count per HOLD & instr_ready edge; wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (advance) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic        jump;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] retired_cnt;

  logic        h_imem_req;
  logic [31:0] h_imem_addr;
  logic [31:0] h_instr;
  logic [5:0]  h_op;
  logic        h_instr_valid;
  logic [31:0] h_pc;
  logic [31:0] h_retired_cnt;

  int n_cmp;
  int n_fail;
  int exp_cnt;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch(branch), .zero(zero), .jump(jump),
    .pc(pc), .retired_cnt(retired_cnt)
  );

  // Second instance in the upper address region, driven in lockstep, to
  // check that a jump keeps pc+4's top nibble.
  instr_fetch_unit #(.RESET_PC(32'h1000_0010)) u_dut_hi (
    .clk(clk), .rst(rst),
    .imem_req(h_imem_req), .imem_addr(h_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(h_instr), .op(h_op), .instr_valid(h_instr_valid),
    .instr_ready(instr_ready), .branch(branch), .zero(zero), .jump(jump),
    .pc(h_pc), .retired_cnt(h_retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] rdata;
    logic        br;
    logic        zf;
    logic        jmp;
    logic [5:0]  exp_op;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_model();
`ifdef INSTR_COUNT_EN
    return exp_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    chk($sformatf("v%0d req_pre", i), {31'd0, imem_req}, 32'd1);
    chk($sformatf("v%0d addr_pre", i), imem_addr, v.exp_pc);
    chk($sformatf("v%0d valid_pre", i), {31'd0, instr_valid}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hA5A5_5A5A;
    chk($sformatf("v%0d valid", i), {31'd0, instr_valid}, 32'd1);
    chk($sformatf("v%0d req_hold", i), {31'd0, imem_req}, 32'd0);
    chk($sformatf("v%0d instr", i), instr, v.rdata);
    chk($sformatf("v%0d op", i), {26'd0, op}, {26'd0, v.exp_op});
    branch      = v.br;
    zero        = v.zf;
    jump        = v.jmp;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    jump        = 1'b0;
    exp_cnt++;
    chk($sformatf("v%0d valid_post", i), {31'd0, instr_valid}, 32'd0);
    chk($sformatf("v%0d req_post", i), {31'd0, imem_req}, 32'd1);
    chk($sformatf("v%0d next_addr", i), imem_addr, v.exp_next);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    exp_cnt = 0;

    //            rdata          br    zf    jmp   op     pc             next
    vecs[0]  = '{32'h0800_0040, 1'b0, 1'b0, 1'b1, 6'd2, 32'h0000_0000, 32'h0000_0100};
    vecs[1]  = '{32'h0800_0002, 1'b0, 1'b0, 1'b1, 6'd2, 32'h0000_0100, 32'h0000_0008};
    vecs[2]  = '{32'h1000_0003, 1'b1, 1'b1, 1'b0, 6'd4, 32'h0000_0008, 32'h0000_0018};
    vecs[3]  = '{32'h0800_0002, 1'b0, 1'b0, 1'b1, 6'd2, 32'h0000_0018, 32'h0000_0008};
    vecs[4]  = '{32'h1000_0003, 1'b1, 1'b0, 1'b0, 6'd4, 32'h0000_0008, 32'h0000_000C};
    vecs[5]  = '{32'h0800_0008, 1'b0, 1'b0, 1'b1, 6'd2, 32'h0000_000C, 32'h0000_0020};
    vecs[6]  = '{32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 6'd4, 32'h0000_0020, 32'h0000_0020};
    vecs[7]  = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 6'd2, 32'h0000_0020, 32'h0000_0100};
    vecs[8]  = '{32'h012A_4020, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0000_0100, 32'h0000_0104};
    vecs[9]  = '{32'h0800_0000, 1'b0, 1'b0, 1'b1, 6'd2, 32'h0000_0104, 32'h0000_0000};
    vecs[10] = '{32'h1000_FFFE, 1'b1, 1'b1, 1'b0, 6'd4, 32'h0000_0000, 32'hFFFF_FFFC};
    vecs[11] = '{32'h8C22_0004, 1'b0, 1'b0, 1'b0, 6'h23, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[12] = '{32'h1000_0003, 1'b0, 1'b1, 1'b0, 6'd4, 32'h0000_0000, 32'h0000_0004};

    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    jump        = 1'b0;

    // Reset held for two cycles.
    step();
    step();
    chk("rst pc", pc, 32'h0);
    chk("rst req", {31'd0, imem_req}, 32'd0);
    chk("rst valid", {31'd0, instr_valid}, 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst cnt", retired_cnt, 32'd0);
    chk("rst hi pc", h_pc, 32'h1000_0010);
    rst = 1'b0;
    #1;
    chk("rel req", {31'd0, imem_req}, 32'd1);
    chk("rel addr", imem_addr, 32'h0);

    // Table-driven instruction stream.
    for (int i = 0; i < 13; i++) begin
      run_vec(i);
      if (i == 0) begin
        chk("hi jump addr", h_imem_addr, 32'h1000_0100);
        chk("hi req", {31'd0, h_imem_req}, 32'd1);
        chk("hi valid", {31'd0, h_instr_valid}, 32'd0);
        chk("hi instr", h_instr, 32'h0800_0040);
        chk("hi op", {26'd0, h_op}, 32'd2);
        chk("hi cnt", h_retired_cnt, cnt_model());
      end
      if (i == 2) chk("cnt after 3", retired_cnt, cnt_model());
    end
    chk("cnt after table", retired_cnt, cnt_model());

    // Delayed ack: request and address stable for 3 cycles (pc=4).
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("wait%0d req", k), {31'd0, imem_req}, 32'd1);
      chk($sformatf("wait%0d addr", k), imem_addr, 32'h4);
      chk($sformatf("wait%0d valid", k), {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h012A_4020;
    step();
    chk("late ack valid", {31'd0, instr_valid}, 32'd1);
    chk("late ack instr", instr, 32'h012A_4020);

    // instr_ready low 4 cycles, stray ack with junk data while in HOLD.
    imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall%0d instr", k), instr, 32'h012A_4020);
      chk($sformatf("stall%0d pc", k), pc, 32'h4);
      chk($sformatf("stall%0d valid", k), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("stall%0d req", k), {31'd0, imem_req}, 32'd0);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    exp_cnt++;
    chk("post stall addr", imem_addr, 32'h8);
    chk("post stall req", {31'd0, imem_req}, 32'd1);
    chk("post stall cnt", retired_cnt, cnt_model());

    // Reset in the middle of REQ, with an ack arriving on the reset edge.
    step();
    chk("midreq addr", imem_addr, 32'h8);
    rst = 1'b1;
    #1;
    chk("midreq rst req", {31'd0, imem_req}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    step();
    exp_cnt = 0;
    chk("midreq pc", pc, 32'h0);
    chk("midreq valid", {31'd0, instr_valid}, 32'd0);
    chk("midreq instr", instr, 32'h0);
    chk("midreq cnt", retired_cnt, 32'd0);
    rst      = 1'b0;
    imem_ack = 1'b0;
    step();
    chk("after rst valid", {31'd0, instr_valid}, 32'd0);
    chk("after rst req", {31'd0, imem_req}, 32'd1);
    chk("after rst addr", imem_addr, 32'h0);
    chk("after rst instr", instr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
